// File: rtl/uart_pkg.sv
// uart_pkg: byte width and sender FSM states shared by the UART transmit path
package uart_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {TX_IDLE, TX_HOLD, TX_DRAIN} tx_state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and sender signals of the shared UART transmit path
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 16
);
  import uart_pkg::*;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [BYTE_W*NUM_REQ-1:0]       req_data;
  logic                            tx_busy;
  logic                            tx_start;
  logic [BYTE_W-1:0]               sdata;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic                            idle;
  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, sdata, fifo_count, idle
  );
  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, sdata, fifo_count, idle
  );
endinterface

// File: rtl/uart_tx_arbiter_byte_fifo.sv
// byte_fifo: synchronous byte FIFO with occupancy count; head is visible on dout
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [BYTE_W-1:0]              din,
  output logic [BYTE_W-1:0]              dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin merge of byte producers into one UART sender via a FIFO
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int FIFO_DEPTH   = 16,
  parameter int BUSY_LATENCY = 2
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0]      ptr, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic               found, full, empty, push, pop, start;
  logic [BYTE_W-1:0]  head, sbyte;
  logic [3:0]         cnt;
  tx_state_t          state;
  always_comb begin
    gnt   = '0;
    gidx  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!found && bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        gidx  = PW'((int'(ptr) + k) % NUM_REQ);
      end
    gnt[gidx] = found;
  end
  assign bus.req_ready = (reset && !full) ? gnt : '0;
  assign push          = |(bus.req_valid & bus.req_ready);
  assign pop           = state == TX_IDLE && !empty && !bus.tx_busy;
  assign bus.tx_start  = start;
  assign bus.sdata     = sbyte;
  assign bus.idle      = empty && state == TX_IDLE;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.req_data[int'(gidx)*BYTE_W +: BYTE_W]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (bus.fifo_count)
  );
  always_ff @(posedge clock)
    if (!reset) ptr <= PW'(NUM_REQ-1);
    else if (push) ptr <= gidx;
  // tx_busy is not trusted until BUSY_LATENCY cycles after the start pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= TX_IDLE;
      start <= 1'b0;
      sbyte <= '0;
      cnt   <= '0;
    end else begin
      start <= pop;
      if (pop) sbyte <= head;
      case (state)
        TX_IDLE:  if (pop) begin
                    state <= TX_HOLD;
                    cnt   <= 4'(BUSY_LATENCY-1);
                  end
        TX_HOLD:  if (cnt == 4'd0) state <= TX_DRAIN;
                  else cnt <= cnt - 4'd1;
        TX_DRAIN: if (!bus.tx_busy) state <= TX_IDLE;
        default:  state <= TX_IDLE;
      endcase
    end
  end
  a_ready_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(bus.req_ready));
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART sender between NUM_REQ byte producers, for example the boot loader's 0x99/0xaa handshake and the CPU's output instruction.
- Round-robin arbitration over valid/ready requester ports.
- Accepted bytes are buffered in a FIFO.
- The FIFO is drained into the sender through the sender's tx_start/sdata/tx_busy interface.
- Sits between the producers and the UART sender, so producers never see tx_busy directly.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
FIFO_DEPTH, 16, byte FIFO entries; power of two, >=2
BUSY_LATENCY, 2, cycles after a tx_start pulse before tx_busy is trusted (1..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  requester i has a byte
req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot grant; byte i accepted when valid[i]&ready[i]
tx_busy  in  1  UART sender busy
tx_start  out  1  one-cycle start pulse to sender
sdata  out  8  byte to sender; valid while tx_start is high
fifo_count  out  $clog2(FIFO_DEPTH+1)  bytes buffered
idle  out  1  FIFO empty and sender FSM in IDLE

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low.
- Reset (reset==0 at posedge):
  - FIFO cleared; fifo_count=0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
  - FSM=IDLE; tx_start=0; sdata=8'h00; idle=1.
  - req_ready is forced to 0 while reset==0, since req_ready is combinational.
- Arbitration (combinational):
  - Scan requesters starting at ptr+1 mod NUM_REQ; the first with req_valid gets the grant.
  - req_ready = grant one-hot & {NUM_REQ{~full}}.
  - At most one ready bit is ever high.
  - ready does not depend on tx_busy.
- Accept:
  - When valid&ready, the byte is written at the FIFO tail at the posedge.
  - ptr <= granted index. ptr changes only on an accepted transfer.
- FIFO:
  - Full means count==FIFO_DEPTH. No push when full; there is no bypass.
  - No pop when empty.
  - Push and pop in the same cycle leaves count unchanged and is legal at any count.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Sender FSM states:
  - IDLE: if ~empty & ~tx_busy: pop head, sdata<=head, tx_start<=1, cnt<=BUSY_LATENCY-1, go HOLD.
  - HOLD: tx_start<=0; tx_busy is ignored; when cnt==0 go DRAIN, else cnt--.
  - DRAIN: when ~tx_busy, go IDLE.
- tx_start is high for exactly one cycle per popped byte. No second pulse may occur until tx_busy has been observed low in DRAIN.
- sdata holds its value until the next pop.
- Latency: a byte accepted in cycle N (FIFO empty, FSM IDLE, tx_busy low) gives tx_start high in cycle N+2.
- Byte ordering:
  - Bytes leave in FIFO order.
  - Per-requester order is preserved.
  - Interleaving between requesters follows the arbitration order.
- Reset mid-operation (any state):
  - Buffered bytes are discarded and the FSM returns to IDLE.
  - A byte already handed to the sender is not recalled.
- Widths: fifo_count is $clog2(FIFO_DEPTH+1) bits; pointers are $clog2(FIFO_DEPTH) bits.

Decomposition:
- Shared package uart_pkg:
  - localparam BYTE_W=8.
  - typedef enum logic [1:0] {TX_IDLE, TX_HOLD, TX_DRAIN} tx_state_t.
- Sub-module byte_fifo:
  - Synchronous, FIFO_DEPTH x 8.
  - Ports push/pop/din/dout/full/empty/count; same clock and active-low reset.
  - Arbitration and the FSM stay in uart_tx_arbiter.

Test Plan:
1. Hold reset=0 for 3 cycles with req_valid=2'b11 -> req_ready=0, tx_start=0 throughout. Release -> fifo_count=0, idle=1, first grant goes to requester 0.
2. Requester 0 sends 8'h41 once; the sender model raises busy 1 cycle after start for 10 cycles -> tx_start is a single pulse 2 cycles after accept with sdata=8'h41. idle=1 after busy falls.
3. Both requesters stream continuously (r0: A0,A1,A2; r1: B0,B1,B2) -> sender sees A0,B0,A1,B1,A2,B2.
4. tx_busy held high; requester 0 offers 18 bytes 0x00..0x11 -> exactly 16 accepted, req_ready low while fifo_count=16. Drop busy -> 0x00..0x0F sent in order, then 0x10,0x11.
5. The sender model raises tx_busy only 2 cycles after tx_start (BUSY_LATENCY=2) -> no duplicate tx_start; each byte is sent once.
6. Reset asserted in DRAIN with 5 bytes buffered -> the next cycle shows fifo_count=0 and idle=1, and no further tx_start occurs after the in-flight byte.
